pico_result_buffer: RTL and testbench

- Downstream stage of the PICOMIPS core.
- Captures the core's 8-bit ALU result and sign flag into a small first-word-fall-through FIFO when the system strobes a capture.
- Presents buffered results to a consumer (display driver / host interface) over a valid/ready handshake.
- Decouples the core's free-running result bus from a slower or stalling consumer, and flags lost results.

---
 rtl/pico_result_buffer.sv | 144 ++++++++++++++
 tb/tb_pico_result_buffer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pico_result_buffer.sv
// FWFT result buffer between the PICOMIPS ALU result bus and a valid/ready consumer.
// Optional RESULT_DEDUP_EN: drop captures equal to the last accepted entry.
module pico_result_buffer #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cap_en,
    input  logic [7:0]    data_in,
    input  logic          sign_in,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [7:0]    rd_data,
    output logic          rd_sign,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    input  logic          clr_ovf
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_e;

    occ_e          occ_q, occ_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [8:0]    mem_q [DEPTH];

    logic [8:0]    entry;
    logic [8:0]    head;
    logic          dup;
    logic          push;
    logic          pop;
    logic          ovf_set;

    assign entry = {sign_in, data_in};
    assign head  = mem_q[rd_ptr_q];

`ifdef RESULT_DEDUP_EN
    logic [8:0] last_q, last_d;
    logic       last_vld_q, last_vld_d;

    assign dup = last_vld_q && (last_q == entry);

    always_comb begin
        last_d     = last_q;
        last_vld_d = last_vld_q;
        if (push) begin
            last_d     = entry;
            last_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign empty    = (occ_q == OCC_EMPTY);
    assign full     = (occ_q == OCC_FULL);
    assign rd_valid = !empty;
    assign count    = count_q;
    assign overflow = ovf_q;
    assign rd_data  = empty ? 8'h00 : head[7:0];
    assign rd_sign  = empty ? 1'b0 : head[8];

    assign pop     = rd_valid && rd_ready;
    assign push    = cap_en && !dup && (!full || pop);
    assign ovf_set = cap_en && !dup && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        occ_d    = occ_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        // set has priority over a coincident clear
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end

        unique case (1'b1)
            (count_d == '0):      occ_d = OCC_EMPTY;
            (count_d == FULL_CNT): occ_d = OCC_FULL;
            default:              occ_d = OCC_PARTIAL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q    <= OCC_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // storage is not reset; the empty-forcing on rd_data hides stale words
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

endmodule

// File: tb/tb_pico_result_buffer.sv
// Scoreboard bench for pico_result_buffer: queue reference model, random and directed traffic.
// Build with +define+RESULT_DEDUP_EN to check the dedup variant.
module tb_pico_result_buffer;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       cap_en;
    logic [7:0] data_in;
    logic       sign_in;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_sign;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       clr_ovf;

    int nvec = 0;
    int nerr = 0;

    logic [8:0] exp_q [$];
    logic       ovf_exp;
    logic [8:0] last_acc;
    logic       last_vld;

    pico_result_buffer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .cap_en   (cap_en),
        .data_in  (data_in),
        .sign_in  (sign_in),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_sign  (rd_sign),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int req);
        nvec++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_status();
        int n;
        n = exp_q.size();
        chk("count", int'(count), n);
        chk("empty", int'(empty), int'(n == 0));
        chk("full", int'(full), int'(n == DEPTH));
        chk("rd_valid", int'(rd_valid), int'(n != 0));
        chk("overflow", int'(overflow), int'(ovf_exp));
        if (n == 0) begin
            chk("rd_data_empty", int'({rd_sign, rd_data}), 0);
        end
    endtask

    // monitor: a transfer is committed at the coming rising edge
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_pop: got 0x%0h, expected no data", {rd_sign, rd_data});
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("rd_data", int'(rd_data), int'(e[7:0]));
                chk("rd_sign", int'(rd_sign), int'(e[8]));
            end
        end
    end

    task automatic step(input logic c, input logic [8:0] v, input logic r, input logic clr);
        logic dup;
        logic is_full;
        logic acc;
        logic oset;
        cap_en   = c;
        data_in  = v[7:0];
        sign_in  = v[8];
        rd_ready = r;
        clr_ovf  = clr;
        chk_status();
        is_full = (exp_q.size() == DEPTH);
        dup = 1'b0;
`ifdef RESULT_DEDUP_EN
        dup = last_vld && (last_acc == v);
`endif
        acc  = c && !dup && (!is_full || r);
        oset = c && !dup && is_full && !r;
        @(posedge clk);
        if (acc) begin
            exp_q.push_back(v);
            last_acc = v;
            last_vld = 1'b1;
        end
        if (oset) ovf_exp = 1'b1;
        else if (clr) ovf_exp = 1'b0;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 9'h000, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 9'h000, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        cap_en   = 1'b0;
        rd_ready = 1'b0;
        clr_ovf  = 1'b0;
        rst      = 1'b1;
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_ovf", int'(overflow), 0);
        exp_q.delete();
        ovf_exp  = 1'b0;
        last_vld = 1'b0;
        last_acc = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        cap_en   = 1'b0;
        data_in  = '0;
        sign_in  = 1'b0;
        rd_ready = 1'b0;
        clr_ovf  = 1'b0;
        ovf_exp  = 1'b0;
        last_vld = 1'b0;
        last_acc = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        step(1'b1, 9'h012, 1'b0, 1'b0);
        step(1'b1, 9'h134, 1'b0, 1'b0);
        step(1'b1, 9'h056, 1'b0, 1'b0);
        chk("three_stored", int'(count), 3);
        drain();
        chk("drained_empty", int'(empty), 1);

        for (int i = 0; i < 3; i++) step(1'b1, 9'(8'h40 + i), 1'b0, 1'b0);
        do_reset();
        idle(1);

        for (int i = 0; i < 4; i++) step(1'b1, 9'(8'hA0 + i), 1'b0, 1'b0);
        step(1'b1, 9'h0FF, 1'b0, 1'b0);
        chk("ovf_set", int'(overflow), 1);
        step(1'b0, 9'h000, 1'b0, 1'b1);
        step(1'b1, 9'h1EE, 1'b0, 1'b1);
        chk("ovf_set_beats_clr", int'(overflow), 1);
        step(1'b0, 9'h000, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 9'(8'h70 + i), 1'b1, 1'b0);
        chk("full_push_pop", int'(count), DEPTH);
        drain();

        do_reset();
        step(1'b1, 9'h005, 1'b0, 1'b0);
        step(1'b1, 9'h005, 1'b0, 1'b0);
        step(1'b1, 9'h006, 1'b0, 1'b0);
        step(1'b1, 9'h005, 1'b0, 1'b0);
`ifdef RESULT_DEDUP_EN
        chk("dedup_count", int'(count), 3);
`else
        chk("dedup_count", int'(count), 4);
`endif
        drain();

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 60), 9'($urandom_range(0, 7)),
                 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 8));
        end
        drain();
        chk("final_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
